// File: rtl/axis_pkt_gen.sv
// ---------------------------------------------------------------------------
// axis_pkt_gen
//   Packet source on a 64-bit keep/last stream. It emits a programmed number
//   of fixed-length packets whose bytes follow a deterministic pattern:
//   payload byte i of packet p is (p[7:0] + i) mod 256. A checker can
//   therefore predict every byte from (packet index, byte offset) alone.
//   A run is only started while aux_resetn is high. Dropping aux_resetn
//   mid-run lets the current packet finish and then ends the run as aborted.
//
// Build option
//   PKTGEN_HDR_EN  when defined, each packet is preceded by one header beat:
//                  {16'hA5A5, 16'h0000, packet index[15:0], pkt_len[15:0]},
//                  KEEP=8'hFF, LAST=0. When undefined, only payload beats
//                  are sent.
//
// Parameters
//   DATA_WIDTH  stream width in bits (only 64 is supported)
//   LEN_W       width of pkt_len, also the payload offset counter (>= 8)
//   CNT_W       width of pkt_count / pkt_sent (>= 8)
//   IDLE_GAP    VALID-low cycles between packets (none before the first)
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   aux_resetn        1 = start permitted; 0 during a run = stop after packet
//   start             start request, honoured only in IDLE
//   pkt_count/pkt_len packets per run / payload bytes per packet (latched)
//   busy              high from start acceptance until the done cycle
//   done              one-cycle end-of-run pulse
//   aborted           run was stopped by aux_resetn (valid with/after done)
//   pkt_sent          packets fully accepted in the current or last run
//   stream_out_*      DATA/KEEP/LAST/VALID out, READY in
// ---------------------------------------------------------------------------
module axis_pkt_gen #(
   parameter int DATA_WIDTH = 64,
   parameter int LEN_W      = 16,
   parameter int CNT_W      = 16,
   parameter int IDLE_GAP   = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    aux_resetn,
   input  logic                    start,
   input  logic [CNT_W-1:0]        pkt_count,
   input  logic [LEN_W-1:0]        pkt_len,
   output logic                    busy,
   output logic                    done,
   output logic                    aborted,
   output logic [CNT_W-1:0]        pkt_sent,
   output logic [DATA_WIDTH-1:0]   stream_out_DATA,
   output logic [DATA_WIDTH/8-1:0] stream_out_KEEP,
   output logic                    stream_out_LAST,
   output logic                    stream_out_VALID,
   input  logic                    stream_out_READY
);

   localparam int KEEP_W = DATA_WIDTH / 8;
   localparam logic [15:0] GAP_LAST = (IDLE_GAP > 0) ? 16'(IDLE_GAP - 1) : 16'd0;

   typedef enum logic [2:0] {
      S_IDLE,
`ifdef PKTGEN_HDR_EN
      S_HDR,
`endif
      S_DATA,
      S_GAP,
      S_DONE
   } state_t;

   // Every packet begins here: the header when enabled, otherwise payload.
`ifdef PKTGEN_HDR_EN
   localparam state_t FIRST_ST = S_HDR;
`else
   localparam state_t FIRST_ST = S_DATA;
`endif

   state_t state, state_nxt;

   logic [CNT_W-1:0]  cnt_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  off_q;
   logic [15:0]       gap_q;

   logic [LEN_W-1:0]  rem;
   logic              beat_last;
   logic              xfer;
   logic              more;
   logic              accept;
   logic [7:0]        base;
   logic [DATA_WIDTH-1:0] pay_data;
   logic [KEEP_W-1:0]     pay_keep;

   // Bytes still owed in this packet; offset never passes len, so no wrap.
   assign rem       = len_q - off_q;
   assign beat_last = (rem <= LEN_W'(KEEP_W));
   assign xfer      = stream_out_VALID && stream_out_READY;
   // pkt_sent doubles as the index of the packet currently on the wire.
   assign more      = ((pkt_sent + CNT_W'(1)) != cnt_q);
   assign accept    = start && aux_resetn;
   assign base      = pkt_sent[7:0] + off_q[7:0];

   always_comb begin
      pay_data = '0;
      pay_keep = '0;
      for (int j = 0; j < KEEP_W; j++) begin
         pay_keep[j] = beat_last ? (LEN_W'(j) < rem) : 1'b1;
         pay_data[8*j +: 8] = pay_keep[j] ? (base + 8'(j)) : 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt        = state;
      busy             = 1'b0;
      done             = 1'b0;
      stream_out_VALID = 1'b0;
      stream_out_DATA  = '0;
      stream_out_KEEP  = '0;
      stream_out_LAST  = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept)
               state_nxt = (pkt_count == '0 || pkt_len == '0) ? S_DONE : FIRST_ST;
         end
`ifdef PKTGEN_HDR_EN
         S_HDR: begin
            busy             = 1'b1;
            stream_out_VALID = 1'b1;
            stream_out_KEEP  = '1;
            stream_out_DATA  = {16'hA5A5, 16'h0000, 16'(pkt_sent), 16'(len_q)};
            if (xfer) state_nxt = S_DATA;
         end
`endif
         S_DATA: begin
            busy             = 1'b1;
            stream_out_VALID = 1'b1;
            stream_out_DATA  = pay_data;
            stream_out_KEEP  = pay_keep;
            stream_out_LAST  = beat_last;
            if (xfer && beat_last) begin
               if (more && aux_resetn)
                  state_nxt = (IDLE_GAP == 0) ? FIRST_ST : S_GAP;
               else
                  state_nxt = S_DONE;
            end
         end
         S_GAP: begin
            busy = 1'b1;
            // Between packets there is nothing to finish, so stop right away.
            if (!aux_resetn)
               state_nxt = S_DONE;
            else if (gap_q == GAP_LAST)
               state_nxt = FIRST_ST;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         len_q    <= '0;
         off_q    <= '0;
         gap_q    <= '0;
         pkt_sent <= '0;
         aborted  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  cnt_q    <= pkt_count;
                  len_q    <= pkt_len;
                  off_q    <= '0;
                  gap_q    <= '0;
                  pkt_sent <= '0;
                  aborted  <= 1'b0;
               end
            end
            S_DATA: begin
               if (xfer) begin
                  if (beat_last) begin
                     off_q    <= '0;
                     gap_q    <= '0;
                     pkt_sent <= pkt_sent + CNT_W'(1);
                     if (!aux_resetn) aborted <= more;
                  end else begin
                     off_q <= off_q + LEN_W'(KEEP_W);
                  end
               end
            end
            S_GAP: begin
               gap_q <= gap_q + 16'd1;
               if (!aux_resetn) aborted <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
